sa_autosa_csb_reg_master: RTL and testbench
===========================================

# sa_autosa_csb_reg_master

Initiator end of the register-file control interface. It accepts CSB register requests from the CSB fabric over a valid/ready channel and checks each request against this unit's 4 KB address window. It drives `reg_offset`, `reg_wr_data` and `reg_wr_en` into the unit's register file, captures `reg_rd_data`, and returns read data or write acknowledges on a valid/ready response channel. One instance sits in front of each unit register file, e.g. in front of the MCIF configuration registers at byte window 0x2000.

## Interface
- `BASE_ADDR`, default 18'h02000: byte base of this unit's window; only bits [17:12] are significant.
- `autosa_core_clk` in 1: clock.
- `autosa_core_rstn` in 1: reset, asynchronous, active-low.
- `req_valid` in 1: request valid.
- `req_ready` out 1: request accepted when high together with `req_valid`.
- `req_addr` in 16: word address; byte address is {req_addr, 2'b00}.
- `req_wdat` in 32: write data.
- `req_write` in 1: 1 = write, 0 = read.
- `req_nposted` in 1: write requires an acknowledge; ignored for reads.
- `rsp_valid` out 1: response valid.
- `rsp_ready` in 1: response accepted.
- `rsp_data` out 32: read data; 0 for write acks.
- `rsp_is_wr` out 1: response is a write acknowledge.
- `rsp_error` out 1: request fell outside the window.
- `reg_offset` out 12: register byte offset to the register file.
- `reg_wr_data` out 32: write data to the register file.
- `reg_wr_en` out 1: single-cycle write strobe.
- `reg_rd_data` in 32: combinational read data from the register file.

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - `req_ready`=1.
  - On `req_valid`&`req_ready`, latch the address, wdat, write and nposted fields, compute `in_win` = (byte_addr[17:12]==BASE_ADDR[17:12]), then go to ACCESS.
- ACCESS (exactly 1 cycle):
  - `reg_offset`=byte_addr[11:0] (registered, loaded at acceptance).
  - `reg_wr_en` = write & in_win.
  - Read: capture `rsp_data` = in_win ? `reg_rd_data` : 0.
  - Write: `rsp_data`=0.
  - Next state: RESP if the request was a read or a nposted write; IDLE if it was a posted write.
- RESP:
  - `rsp_valid`=1; `rsp_data`, `rsp_is_wr` and `rsp_error` are stable while held.
  - On `rsp_ready`, go to IDLE.
  - `req_ready`=0 throughout ACCESS and RESP; there is only one request in flight.
- `reg_offset` and `reg_wr_data` hold their last value outside ACCESS.
- `reg_wr_en` is never asserted outside ACCESS.
- Out-of-window write: no `reg_wr_en`.
- Out-of-window read: no side effect on the register file.

## Timing
- Reset values: state=IDLE, `req_ready`=1, `rsp_valid`=0, `rsp_data`=0, `rsp_is_wr`=0, `rsp_error`=0, `reg_offset`=0, `reg_wr_data`=0, `reg_wr_en`=0.
- Request accepted in cycle T: ACCESS at T+1, `reg_wr_en` high in T+1, `rsp_valid` first high at T+2.
- Throughput:
  - Posted write: 1 request per 2 cycles.
  - Read or nposted write: 1 request per 3 cycles with `rsp_ready` held high.
- `rsp_ready` held low: `rsp_valid` and the payload remain asserted indefinitely and `req_ready` stays 0.
- `rsp_ready` high before `rsp_valid`: no effect.
- Reset mid-operation: the FSM returns to IDLE asynchronously and any pending response is discarded. A write whose ACCESS cycle completed before reset is not undone.

## Configuration
- `SA_AUTOSA_CSB_ERR_RSP_EN`:
  - Defined: out-of-window requests set `rsp_error`=1. Out-of-window posted writes are promoted to nposted so that the error is reported.
  - Undefined: `rsp_error` is tied to 0, out-of-window posted writes are silently dropped, and out-of-window reads return 0 with no error.

## Structure
- A shared package `sa_autosa_csb_pkg` holds:
  - the FSM state enum;
  - the request field widths (address 16, data 32, offset 12);
  - a packed request struct;
  - the window-match helper function.
- No sub-module: a single flat module.

## Test plan
- Reset, then read byte 0x2014 (`req_addr`=0x0805) -> `reg_offset`=0x014, `rsp_valid` at T+2, `rsp_data`=0x0000FFFF, `rsp_is_wr`=0, `rsp_error`=0.
- Nposted write 0x04030201 to 0x2000 -> `reg_wr_en` one cycle at T+1 with `reg_wr_data`=0x04030201; ack has `rsp_is_wr`=1, `rsp_data`=0. A following read of 0x2000 returns 0x04030201.
- Posted write to 0x2004 -> `reg_wr_en` pulses once, no `rsp_valid`, `req_ready` high again at T+2.
- Read of byte 0x3000 with macro defined -> no `reg_wr_en`, `rsp_error`=1, `rsp_data`=0. Without macro -> `rsp_error`=0, `rsp_data`=0.
- `rsp_ready` held low 5 cycles during RESP -> `rsp_valid` and data stable, `req_ready`=0; new `req_valid` is not accepted until the cycle after the `rsp_ready` handshake.
- Assert `autosa_core_rstn` low while in RESP -> `rsp_valid`=0 and `req_ready`=1 immediately; the next read completes normally.

Source files
------------

// File: rtl/sa_autosa_csb_pkg.sv
// sa_autosa_csb_pkg: shared types and window-match helper for the CSB register master.
package sa_autosa_csb_pkg;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 32;
  localparam int OFF_W  = 12;
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;
  typedef struct packed {
    logic [OFF_W-1:0]  offset;
    logic [DATA_W-1:0] wdat;
    logic              write;
    logic              nposted;
    logic              in_win;
  } csb_req_t;
  // Word address bits [15:10] are byte address bits [17:12], the 4 KB window select.
  function automatic logic in_window(input logic [ADDR_W-1:0] addr, input logic [5:0] base_hi);
    return addr[ADDR_W-1:ADDR_W-6] == base_hi;
  endfunction
endpackage

// File: rtl/sa_autosa_csb_reg_master.sv
// sa_autosa_csb_reg_master: CSB request to register-file access bridge, one request in flight.
// SA_AUTOSA_CSB_ERR_RSP_EN: report out-of-window requests with rsp_error (posted writes promoted).
module sa_autosa_csb_reg_master
  import sa_autosa_csb_pkg::*;
#(
  parameter logic [17:0] BASE_ADDR = 18'h02000
) (
  input  logic              autosa_core_clk,
  input  logic              autosa_core_rstn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdat,
  input  logic              req_write,
  input  logic              req_nposted,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_is_wr,
  output logic              rsp_error,
  output logic [OFF_W-1:0]  reg_offset,
  output logic [DATA_W-1:0] reg_wr_data,
  output logic              reg_wr_en,
  input  logic [DATA_W-1:0] reg_rd_data
);
`ifdef SA_AUTOSA_CSB_ERR_RSP_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif
  localparam logic [5:0] BASE_HI = BASE_ADDR[17:12];
  state_e            state_q, state_d;
  csb_req_t          req_q, req_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              rsp_is_wr_q, rsp_is_wr_d;
  logic              rsp_error_q, rsp_error_d;
  logic              need_rsp;
  assign need_rsp = !req_q.write || req_q.nposted || (ERR_EN && !req_q.in_win);
  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    rsp_data_d  = rsp_data_q;
    rsp_is_wr_d = rsp_is_wr_q;
    rsp_error_d = rsp_error_q;
    if (state_q == IDLE && req_valid) begin
      req_d   = '{offset:  {req_addr[OFF_W-3:0], 2'b00},
                  wdat:    req_wdat,
                  write:   req_write,
                  nposted: req_nposted,
                  in_win:  in_window(req_addr, BASE_HI)};
      state_d = ACCESS;
    end
    if (state_q == ACCESS) begin
      rsp_data_d  = (!req_q.write && req_q.in_win) ? reg_rd_data : '0;
      rsp_is_wr_d = req_q.write;
      rsp_error_d = ERR_EN && !req_q.in_win;
      state_d     = need_rsp ? RESP : IDLE;
    end
    if (state_q == RESP && rsp_ready) state_d = IDLE;
  end
  always_ff @(posedge autosa_core_clk or negedge autosa_core_rstn) begin
    if (!autosa_core_rstn) begin
      state_q     <= IDLE;
      req_q       <= '0;
      rsp_data_q  <= '0;
      rsp_is_wr_q <= 1'b0;
      rsp_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      rsp_data_q  <= rsp_data_d;
      rsp_is_wr_q <= rsp_is_wr_d;
      rsp_error_q <= rsp_error_d;
    end
  end
  assign req_ready   = state_q == IDLE;
  assign rsp_valid   = state_q == RESP;
  assign rsp_data    = rsp_data_q;
  assign rsp_is_wr   = rsp_is_wr_q;
  assign rsp_error   = rsp_error_q;
  assign reg_offset  = req_q.offset;
  assign reg_wr_data = req_q.wdat;
  assign reg_wr_en   = state_q == ACCESS && req_q.write && req_q.in_win;
endmodule

// File: tb/tb_sa_autosa_csb_reg_master.sv
// tb_sa_autosa_csb_reg_master: directed CSB transactions checked against a transaction-level model.
module tb_sa_autosa_csb_reg_master;
`ifdef SA_AUTOSA_CSB_ERR_RSP_EN
  localparam logic ERR = 1'b1;
`else
  localparam logic ERR = 1'b0;
`endif
  logic        clk = 1'b0, rstn = 1'b0;
  logic        req_valid, req_ready, req_write, req_nposted;
  logic [15:0] req_addr;
  logic [31:0] req_wdat, rsp_data, reg_wr_data, reg_rd_data;
  logic        rsp_valid, rsp_ready, rsp_is_wr, rsp_error, reg_wr_en;
  logic [11:0] reg_offset;
  always #5 clk = ~clk;
  sa_autosa_csb_reg_master dut (
    .autosa_core_clk(clk), .autosa_core_rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_wdat(req_wdat), .req_write(req_write), .req_nposted(req_nposted),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_is_wr(rsp_is_wr), .rsp_error(rsp_error), .reg_offset(reg_offset),
    .reg_wr_data(reg_wr_data), .reg_wr_en(reg_wr_en), .reg_rd_data(reg_rd_data)
  );
  logic [31:0] rf [0:1023];
  assign reg_rd_data = rf[reg_offset[11:2]];
  always @(posedge clk) if (reg_wr_en) rf[reg_offset[11:2]] = reg_wr_data;
  typedef struct {logic [31:0] data; logic is_wr; logic err; int cyc;} rsp_t;
  typedef struct {logic [11:0] off; logic [31:0] data; int cyc;} wr_t;
  rsp_t        rq[$];
  wr_t         wq[$];
  logic [31:0] mem [0:1023];
  int          cyc = 0, total = 0, bad = 0;
  bit          seen = 0;
  logic [31:0] last_data;
  logic        last_is_wr, last_err;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  always @(negedge clk) if (rstn) begin
    if (reg_wr_en) begin
      if (wq.size() == 0) chk("spurious wr_en", {31'd0, reg_wr_en}, 32'd0);
      else begin
        chk("wr offset", {20'd0, reg_offset}, {20'd0, wq[0].off});
        chk("wr data", reg_wr_data, wq[0].data);
        chk("wr cycle", cyc, wq[0].cyc);
        void'(wq.pop_front());
      end
    end else if (wq.size() != 0 && cyc >= wq[0].cyc) begin
      chk("wr_en missing", {31'd0, reg_wr_en}, 32'd1);
      void'(wq.pop_front());
    end
    if (rsp_valid) begin
      if (rq.size() == 0) chk("spurious rsp", {31'd0, rsp_valid}, 32'd0);
      else begin
        chk("rsp data", rsp_data, rq[0].data);
        chk("rsp is_wr", {31'd0, rsp_is_wr}, {31'd0, rq[0].is_wr});
        chk("rsp error", {31'd0, rsp_error}, {31'd0, rq[0].err});
        if (!seen) chk("rsp latency", cyc, rq[0].cyc);
        seen = 1;
        if (rsp_ready) begin
          last_data = rsp_data; last_is_wr = rsp_is_wr; last_err = rsp_error;
          void'(rq.pop_front());
          seen = 0;
        end
      end
    end else if (rq.size() != 0 && !seen && cyc >= rq[0].cyc) begin
      chk("rsp missing", {31'd0, rsp_valid}, 32'd1);
      void'(rq.pop_front());
    end
  end
  task automatic issue(input logic [15:0] a, input logic [31:0] d, input logic w, input logic np,
                       output int t);
    logic [17:0] b;
    logic        win;
    rsp_t        r;
    wr_t         x;
    b   = {a, 2'b00};
    win = b[17:12] == 6'h02;
    @(posedge clk); #1;
    req_valid = 1; req_addr = a; req_wdat = d; req_write = w; req_nposted = np;
    t = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (req_ready) begin t = cyc; break; end
    end
    if (t < 0) chk("accept timeout", {31'd0, req_ready}, 32'd1);
    else begin
      if (w && win) begin
        x = '{b[11:0], d, t + 1};
        wq.push_back(x);
        mem[b[11:2]] = d;
      end
      if (!w || np || (ERR && !win)) begin
        r = '{(w || !win) ? 32'h0 : mem[b[11:2]], w, ERR && !win, t + 2};
        rq.push_back(r);
      end
    end
    @(posedge clk); #1;
    req_valid = 0;
  endtask
  task automatic drain();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (rq.size() == 0 && wq.size() == 0) return;
    end
    chk("drain timeout", rq.size() + wq.size(), 32'd0);
  endtask
  task automatic wait_rsp_valid();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rsp_valid) return;
    end
    chk("rsp_valid timeout", {31'd0, rsp_valid}, 32'd1);
  endtask
  initial begin
    int t, tb_acc, h;
    for (int i = 0; i < 1024; i++) begin rf[i] = 32'h0000FFFF; mem[i] = 32'h0000FFFF; end
    req_valid = 0; req_addr = 0; req_wdat = 0; req_write = 0; req_nposted = 0; rsp_ready = 1;
    #12;
    chk("reset req_ready", {31'd0, req_ready}, 32'd1);
    chk("reset rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("reset rsp_data", rsp_data, 32'd0);
    chk("reset rsp_is_wr", {31'd0, rsp_is_wr}, 32'd0);
    chk("reset rsp_error", {31'd0, rsp_error}, 32'd0);
    chk("reset reg_offset", {20'd0, reg_offset}, 32'd0);
    chk("reset reg_wr_data", reg_wr_data, 32'd0);
    chk("reset reg_wr_en", {31'd0, reg_wr_en}, 32'd0);
    #1 rstn = 1;
    issue(16'h0805, 32'h0, 0, 0, t); drain();
    chk("read 2014 offset", {20'd0, reg_offset}, 32'h014);
    chk("read 2014 data", last_data, 32'h0000FFFF);
    chk("read 2014 is_wr", {31'd0, last_is_wr}, 32'd0);
    chk("read 2014 error", {31'd0, last_err}, 32'd0);
    issue(16'h0800, 32'h04030201, 1, 1, t); drain();
    chk("npwr ack is_wr", {31'd0, last_is_wr}, 32'd1);
    chk("npwr ack data", last_data, 32'd0);
    issue(16'h0800, 32'h0, 0, 0, t); drain();
    chk("read back 2000", last_data, 32'h04030201);
    issue(16'h0801, 32'hA5A50001, 1, 0, t);
    @(negedge clk) chk("posted busy T+1", {31'd0, req_ready}, 32'd0);
    @(negedge clk) chk("posted ready T+2", {31'd0, req_ready}, 32'd1);
    drain();
    issue(16'h0C00, 32'h0, 0, 0, t); drain();
    chk("oow read error", {31'd0, last_err}, {31'd0, ERR});
    chk("oow read data", last_data, 32'd0);
    issue(16'h0C01, 32'hDEAD0000, 1, 0, t); drain();
    issue(16'h0801, 32'h0, 0, 0, t); drain();
    chk("oow write no effect", last_data, 32'hA5A50001);
    rsp_ready = 0;
    issue(16'h0805, 32'h0, 0, 0, t);
    fork
      issue(16'h0802, 32'h0, 0, 0, tb_acc);
      begin
        wait_rsp_valid();
        repeat (5) begin
          @(negedge clk);
          chk("hold rsp_valid", {31'd0, rsp_valid}, 32'd1);
          chk("hold req_ready", {31'd0, req_ready}, 32'd0);
        end
        @(posedge clk); #1 rsp_ready = 1;
        @(negedge clk) h = cyc;
      end
    join
    chk("accept after handshake", tb_acc, h + 1);
    drain();
    rsp_ready = 0;
    issue(16'h0800, 32'h0, 0, 0, t);
    wait_rsp_valid();
    #2 rstn = 0;
    rq.delete(); seen = 0;
    #1;
    chk("async reset rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("async reset req_ready", {31'd0, req_ready}, 32'd1);
    @(negedge clk); #1 rstn = 1; rsp_ready = 1;
    issue(16'h0800, 32'h0, 0, 0, t); drain();
    chk("read after reset", last_data, 32'h04030201);
    chk("queues empty", rq.size() + wq.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
